// File: rtl/iterative_shifter_if.sv
// Handshake and data bundle for iterative_shifter.
// The master drives requests and operands; the slave returns status and result.
interface iterative_shifter_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 4
) ();

  logic             start;
  logic [1:0]       mode;
  logic             norm;
  logic [CNT_W-1:0] shift_count;
  logic [WIDTH-1:0] x;

  logic             busy;
  logic             done;
  logic [WIDTH-1:0] r;
  logic [CNT_W-1:0] shamt;
  logic             zero;

  modport master (
    output start, mode, norm, shift_count, x,
    input  busy, done, r, shamt, zero
  );

  modport slave (
    input  start, mode, norm, shift_count, x,
    output busy, done, r, shamt, zero
  );

endinterface

// File: rtl/iterative_shifter.sv
// Multi-cycle shifter: one binary-weighted stage per clock (LSL/LSR/ASR/ROR).
// Normalise mode is built only when ITERATIVE_SHIFTER_NORMALIZE_EN is defined.
module iterative_shifter #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  iterative_shifter_if.slave bus
);

  if (WIDTH != (1 << CNT_W)) begin : g_width_check
    $error("iterative_shifter: WIDTH (%0d) must equal 2**CNT_W (%0d)", WIDTH, 1 << CNT_W);
  end

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;
  typedef enum logic [1:0] {ModeLsl = 2'b00, ModeLsr = 2'b01, ModeAsr = 2'b10,
                            ModeRor = 2'b11} mode_e;

  state_e           state_q;
  mode_e            mode_q;
  logic [WIDTH-1:0] work_q, work_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] stage_q;
  logic [CNT_W-1:0] step;
  logic             busy_q, done_q, zero_q;
  logic [WIDTH-1:0] r_q;
  logic [CNT_W-1:0] shamt_q;

  // 2^k serves both as the shift distance and as the count-bit mask for stage k.
  assign step = CNT_W'(1) << stage_q;

`ifdef ITERATIVE_SHIFTER_NORMALIZE_EN
  logic             norm_q;
  logic [WIDTH-1:0] top_mask;

  assign top_mask = ~({WIDTH{1'b1}} >> step);
`else
  logic unused_norm;

  assign unused_norm = bus.norm;
`endif

  always_comb begin
    work_d  = work_q;
    count_d = count_q;
    if ((count_q & step) != '0) begin
      case (mode_q)
        ModeLsl: work_d = work_q << step;
        ModeLsr: work_d = work_q >> step;
        ModeAsr: work_d = WIDTH'($signed(work_q) >>> step);
        // Left amount is WIDTH - step, taken modulo WIDTH via the CNT_W-bit wrap.
        ModeRor: work_d = (work_q >> step) | (work_q << (CNT_W'(0) - step));
        default: work_d = work_q;
      endcase
    end
`ifdef ITERATIVE_SHIFTER_NORMALIZE_EN
    if (norm_q) begin
      work_d  = work_q;
      count_d = count_q;
      if ((work_q & top_mask) == '0) begin
        work_d  = work_q << step;
        count_d = count_q | step;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      mode_q  <= ModeLsl;
      work_q  <= '0;
      count_q <= '0;
      stage_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      r_q     <= '0;
      shamt_q <= '0;
      zero_q  <= 1'b1;
`ifdef ITERATIVE_SHIFTER_NORMALIZE_EN
      norm_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        StIdle, StDone: begin
          done_q <= 1'b0;
          if (bus.start) begin
            state_q <= StShift;
            busy_q  <= 1'b1;
            mode_q  <= mode_e'(bus.mode);
            work_q  <= bus.x;
            stage_q <= CNT_W'(CNT_W - 1);
`ifdef ITERATIVE_SHIFTER_NORMALIZE_EN
            norm_q  <= bus.norm;
            // Normalise accumulates the leading-zero count from zero.
            count_q <= bus.norm ? '0 : bus.shift_count;
`else
            count_q <= bus.shift_count;
`endif
          end else begin
            state_q <= StIdle;
          end
        end
        StShift: begin
          work_q  <= work_d;
          count_q <= count_d;
          stage_q <= stage_q - CNT_W'(1);
          if (stage_q == '0) begin
            state_q <= StDone;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            r_q     <= work_d;
            shamt_q <= count_d;
            zero_q  <= (work_d == '0);
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.r     = r_q;
  assign bus.shamt = shamt_q;
  assign bus.zero  = zero_q;

endmodule

// File: tb/tb_iterative_shifter.sv
// Scoreboard bench for iterative_shifter: expected results queued at start, checked on done.
module tb_iterative_shifter;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned CNT_W = 4;
`ifdef ITERATIVE_SHIFTER_NORMALIZE_EN
  localparam bit NormEn = 1'b1;
`else
  localparam bit NormEn = 1'b0;
`endif

  typedef struct packed {
    logic [WIDTH-1:0] r;
    logic [CNT_W-1:0] shamt;
    logic             zero;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;

  iterative_shifter_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  iterative_shifter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  function automatic exp_t model(input logic [1:0] m, input logic [3:0] c,
                                 input logic [15:0] v, input logic n);
    logic [15:0] t;
    logic [3:0]  s;
    t = v;
    s = c;
    if (n && NormEn) begin
      s = 4'd0;
      if (v == 16'h0) s = 4'd15;
      else while (!t[15]) begin t = t << 1; s = s + 4'd1; end
    end else begin
      case (m)
        2'd0:    t = v << c;
        2'd1:    t = v >> c;
        2'd2:    t = $signed(v) >>> c;
        default: for (int i = 0; i < int'(c); i++) t = {t[0], t[15:1]};
      endcase
    end
    return {t, s, (t == 16'h0)};
  endfunction

  function automatic exp_t pop_exp();
    if (sb.size() > 0) return sb.pop_front();
    return '0;
  endfunction

  task automatic rand_inputs();
    bus.mode        = 2'($urandom_range(0, 3));
    bus.shift_count = 4'($urandom_range(0, 15));
    bus.x           = 16'($urandom);
    bus.norm        = 1'($urandom_range(0, 1));
  endtask

  task automatic issue(input logic [1:0] m, input logic [3:0] c, input logic [15:0] v,
                       input logic n, input exp_t e);
    @(negedge clk);
    bus.start       = 1'b1;
    bus.mode        = m;
    bus.shift_count = c;
    bus.x           = v;
    bus.norm        = n;
    sb.push_back(e);
  endtask

  // Drops start and scrambles operands each cycle while waiting (bounded) for done.
  task automatic wait_done(output bit seen, output int busy_n);
    seen   = 1'b0;
    busy_n = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
      rand_inputs();
      if (bus.done) seen = 1'b1;
      else if (bus.busy) busy_n++;
    end
  endtask

  task automatic test_reset();
    #12;
    n_vec++;
    if ({bus.busy, bus.done, bus.r, bus.shamt, bus.zero} !== {1'b0, 1'b0, 16'h0, 4'h0, 1'b1}) begin
      n_miss++;
      $display("FAIL reset_hold: got busy=%b done=%b r=%h shamt=%0d zero=%b, want 0 0 0000 0 1",
               bus.busy, bus.done, bus.r, bus.shamt, bus.zero);
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_vec++;
    if ({bus.busy, bus.done, bus.r, bus.shamt, bus.zero} !== {1'b0, 1'b0, 16'h0, 4'h0, 1'b1}) begin
      n_miss++;
      $display("FAIL reset_release: got busy=%b done=%b r=%h shamt=%0d zero=%b, want 0 0 0000 0 1",
               bus.busy, bus.done, bus.r, bus.shamt, bus.zero);
    end
  endtask

  task automatic test_lsl();
    bit seen; int nb; exp_t e;
    issue(2'd0, 4'd5, 16'h0001, 1'b0, {16'h0020, 4'd5, 1'b0});
    wait_done(seen, nb);
    e = pop_exp();
    n_vec++;
    if (!seen) begin n_miss++; $display("FAIL lsl_done: done=0 after bound, want 1"); end
    n_vec++;
    if (nb != CNT_W) begin n_miss++; $display("FAIL lsl_busy: got %0d busy cycles, want %0d", nb, CNT_W); end
    n_vec++;
    if ({bus.r, bus.shamt, bus.zero} !== e) begin
      n_miss++;
      $display("FAIL lsl_result: got r=%h shamt=%0d zero=%b, want r=%h shamt=%0d zero=%b",
               bus.r, bus.shamt, bus.zero, e.r, e.shamt, e.zero);
    end
    @(negedge clk);
    n_vec++;
    if ({bus.done, bus.busy, bus.r} !== {1'b0, 1'b0, e.r}) begin
      n_miss++;
      $display("FAIL lsl_after: got done=%b busy=%b r=%h, want done=0 busy=0 r=%h",
               bus.done, bus.busy, bus.r, e.r);
    end
  endtask

  task automatic test_shift_modes();
    logic [1:0]  tm [3] = '{2'd2, 2'd1, 2'd0};
    logic [15:0] tx [3] = '{16'h8000, 16'h8000, 16'h0002};
    exp_t        te [3] = '{{16'hFFFF, 4'd15, 1'b0}, {16'h0001, 4'd15, 1'b0},
                            {16'h0000, 4'd15, 1'b1}};
    bit seen; int nb; exp_t e;
    logic [1:0] m; logic [3:0] c; logic [15:0] v;
    for (int i = 0; i < 7; i++) begin
      if (i < 3) begin
        issue(tm[i], 4'd15, tx[i], 1'b0, te[i]);
      end else begin
        m = 2'($urandom_range(0, 3));
        c = 4'($urandom_range(0, 15));
        v = 16'($urandom);
        issue(m, c, v, 1'b0, model(m, c, v, 1'b0));
      end
      wait_done(seen, nb);
      e = pop_exp();
      n_vec++;
      if (!seen || {bus.r, bus.shamt, bus.zero} !== e) begin
        n_miss++;
        $display("FAIL modes_%0d: seen=%b got r=%h shamt=%0d zero=%b, want r=%h shamt=%0d zero=%b",
                 i, seen, bus.r, bus.shamt, bus.zero, e.r, e.shamt, e.zero);
      end
    end
  endtask

  task automatic test_ror();
    logic [3:0] tc [2] = '{4'd4, 4'd0};
    exp_t       te [2] = '{{16'h4123, 4'd4, 1'b0}, {16'h1234, 4'd0, 1'b0}};
    bit seen; int nb; exp_t e;
    for (int i = 0; i < 2; i++) begin
      issue(2'd3, tc[i], 16'h1234, 1'b0, te[i]);
      wait_done(seen, nb);
      e = pop_exp();
      n_vec++;
      if (!seen || nb != CNT_W || {bus.r, bus.shamt, bus.zero} !== e) begin
        n_miss++;
        $display("FAIL ror_%0d: seen=%b busy=%0d got r=%h shamt=%0d zero=%b, want busy=%0d r=%h shamt=%0d zero=%b",
                 i, seen, nb, bus.r, bus.shamt, bus.zero, CNT_W, e.r, e.shamt, e.zero);
      end
    end
  endtask

  task automatic test_norm();
    bit seen; int nb; exp_t e;
    exp_t te [3];
    logic [1:0]  tm [3] = '{2'd0, 2'd0, 2'd1};
    logic [3:0]  tc [3] = '{4'd1, 4'd1, 4'd3};
    logic [15:0] tx [3] = '{16'h0010, 16'h0000, 16'h0300};
    te[0] = NormEn ? exp_t'({16'h8000, 4'd11, 1'b0}) : exp_t'({16'h0020, 4'd1, 1'b0});
    te[1] = NormEn ? exp_t'({16'h0000, 4'd15, 1'b1}) : exp_t'({16'h0000, 4'd1, 1'b1});
    te[2] = model(tm[2], tc[2], tx[2], 1'b1);
    for (int i = 0; i < 3; i++) begin
      issue(tm[i], tc[i], tx[i], 1'b1, te[i]);
      wait_done(seen, nb);
      e = pop_exp();
      n_vec++;
      if (!seen || nb != CNT_W || {bus.r, bus.shamt, bus.zero} !== e) begin
        n_miss++;
        $display("FAIL norm_%0d: seen=%b busy=%0d got r=%h shamt=%0d zero=%b, want r=%h shamt=%0d zero=%b",
                 i, seen, nb, bus.r, bus.shamt, bus.zero, e.r, e.shamt, e.zero);
      end
    end
  endtask

  task automatic test_back_to_back();
    int cyc = 0, last = -1, ndone = 0;
    exp_t e;
    @(negedge clk);
    rand_inputs();
    bus.start = 1'b1;
    sb.push_back(model(bus.mode, bus.shift_count, bus.x, bus.norm));
    while (ndone < 6 && cyc < 80) begin
      @(negedge clk);
      cyc++;
      n_vec++;
      if (bus.busy && bus.done) begin
        n_miss++;
        $display("FAIL b2b_overlap: busy=1 done=1 at cycle %0d, want never both", cyc);
      end
      if (bus.done) begin
        e = pop_exp();
        n_vec++;
        if ({bus.r, bus.shamt, bus.zero} !== e) begin
          n_miss++;
          $display("FAIL b2b_result_%0d: got r=%h shamt=%0d zero=%b, want r=%h shamt=%0d zero=%b",
                   ndone, bus.r, bus.shamt, bus.zero, e.r, e.shamt, e.zero);
        end
        if (last >= 0) begin
          n_vec++;
          if (cyc - last != CNT_W + 1) begin
            n_miss++;
            $display("FAIL b2b_interval: got %0d cycles between done, want %0d", cyc - last, CNT_W + 1);
          end
        end
        last = cyc;
        ndone++;
      end
      rand_inputs();
      if (bus.done && ndone < 6) sb.push_back(model(bus.mode, bus.shift_count, bus.x, bus.norm));
      if (ndone >= 6) bus.start = 1'b0;
    end
    n_vec++;
    if (ndone != 6) begin n_miss++; $display("FAIL b2b_count: got %0d done pulses, want 6", ndone); end
    bus.start = 1'b0;
    sb.delete();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid_shift();
    bit seen; int nb, nd; exp_t e;
    issue(2'd0, 4'd5, 16'h0001, 1'b0, {16'h0020, 4'd5, 1'b0});
    wait_done(seen, nb);
    e = pop_exp();
    n_vec++;
    if (!seen || {bus.r, bus.shamt, bus.zero} !== e) begin
      n_miss++;
      $display("FAIL rst_pre: seen=%b got r=%h shamt=%0d zero=%b, want r=%h shamt=%0d zero=%b",
               seen, bus.r, bus.shamt, bus.zero, e.r, e.shamt, e.zero);
    end
    issue(2'd1, 4'd3, 16'hF000, 1'b0, {16'h1E00, 4'd3, 1'b0});
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_vec++;
    if ({bus.busy, bus.done, bus.r, bus.shamt, bus.zero} !== {1'b0, 1'b0, 16'h0, 4'h0, 1'b1}) begin
      n_miss++;
      $display("FAIL rst_mid: got busy=%b done=%b r=%h shamt=%0d zero=%b, want 0 0 0000 0 1",
               bus.busy, bus.done, bus.r, bus.shamt, bus.zero);
    end
    sb.delete();
    @(negedge clk);
    reset = 1'b1;
    nd = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.done || bus.busy) nd++;
    end
    n_vec++;
    if (nd != 0) begin n_miss++; $display("FAIL rst_quiet: got %0d busy/done cycles, want 0", nd); end
    issue(2'd1, 4'd4, 16'h00F0, 1'b0, {16'h000F, 4'd4, 1'b0});
    wait_done(seen, nb);
    e = pop_exp();
    n_vec++;
    if (!seen || nb != CNT_W || {bus.r, bus.shamt, bus.zero} !== e) begin
      n_miss++;
      $display("FAIL rst_post: seen=%b busy=%0d got r=%h shamt=%0d zero=%b, want r=%h shamt=%0d zero=%b",
               seen, nb, bus.r, bus.shamt, bus.zero, e.r, e.shamt, e.zero);
    end
  endtask

  initial begin
    bus.start       = 1'b0;
    bus.mode        = 2'd0;
    bus.norm        = 1'b0;
    bus.shift_count = 4'd0;
    bus.x           = 16'h0;
    test_reset();
    test_lsl();
    test_shift_modes();
    test_ror();
    test_norm();
    test_back_to_back();
    test_reset_mid_shift();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
